// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch squash,
// data-memory wait with timeout and a saturating stall counter.
module hazard_stall_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  en_single,
  output logic                  ifid_flush,
  output logic                  pipe_hold,
  output logic                  mem_timeout,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int WC_W = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;

  logic load_use;
  logic mem_stall;
  logic sel_err, sel_hold, sel_br, sel_lu;
  logic pc_w, ifid_w, en_s, flush, hold;

  // Hazard detection on the current ID/EX operands
  always_comb begin
    load_use  = ex_mem_read & (ex_rt != '0) &
                ((ex_rt == id_rs) |
                 (id_uses_rt & (ex_rt == id_rt)));
    mem_stall = mem_req & ~mem_ready;
  end

  // Select which hazard wins this cycle and compute next state
  always_comb begin
    sel_err        = 1'b0;
    sel_hold       = 1'b0;
    sel_br         = 1'b0;
    sel_lu         = 1'b0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          sel_hold   = 1'b1;
          state_d    = MEM_WAIT;
          wait_cnt_d = WC_W'(1);
        end else begin
          sel_br = branch_taken;
          sel_lu = ~branch_taken & load_use;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          sel_hold   = 1'b1;
          wait_cnt_d = wait_cnt_q + WC_W'(1);
          if (wait_cnt_q == WC_LAST) begin
            state_d       = ERR;
            mem_timeout_d = 1'b1;
          end
        end else begin
          state_d    = RUN;
          wait_cnt_d = '0;
          sel_br     = branch_taken;
          sel_lu     = ~branch_taken & load_use;
        end
      end
      ERR: begin
        sel_err = 1'b1;
      end
      default: begin
        sel_err = 1'b1;
        state_d = ERR;
      end
    endcase
  end

  // Decode the winning hazard into pipeline control
  always_comb begin
    pc_w   = 1'b1;
    ifid_w = 1'b1;
    en_s   = 1'b1;
    flush  = 1'b0;
    hold   = 1'b0;
    unique case (1'b1)
      sel_err: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        en_s   = 1'b0;
        hold   = 1'b1;
      end
      sel_hold: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        hold   = 1'b1;
      end
      sel_br: begin
        flush = 1'b1;
        en_s  = 1'b0;
      end
      sel_lu: begin
        pc_w   = 1'b0;
        ifid_w = 1'b0;
        en_s   = 1'b0;
      end
      default: ;
    endcase
  end

  // Saturating count of cycles in which the PC is held
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!pc_w && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  // Outputs forced to a frozen, bubbled pipeline while in reset
  always_comb begin
    pc_write     = rst_n & pc_w;
    ifid_write   = rst_n & ifid_w;
    en_single    = rst_n & en_s;
    ifid_flush   = rst_n & flush;
    pipe_hold    = ~rst_n | hold;
    mem_timeout  = mem_timeout_q;
    stall_cycles = stall_cycles_q;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      wait_cnt_q     <= '0;
      mem_timeout_q  <= 1'b0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: load-use, branch squash,
// memory wait, timeout, async reset and counter saturation.
module tb_hazard_stall_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, branch_taken;
  logic        mem_req, mem_ready;
  logic        pc_write, ifid_write, en_single;
  logic        ifid_flush, pipe_hold, mem_timeout;
  logic [15:0] stall_cycles;
  logic        pc_write4, ifid_write4, en_single4;
  logic        ifid_flush4, pipe_hold4, mem_timeout4;
  logic [3:0]  stall_cycles4;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write), .ifid_write(ifid_write),
    .en_single(en_single), .ifid_flush(ifid_flush),
    .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_write(pc_write4), .ifid_write(ifid_write4),
    .en_single(en_single4), .ifid_flush(ifid_flush4),
    .pipe_hold(pipe_hold4), .mem_timeout(mem_timeout4),
    .stall_cycles(stall_cycles4)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_mem_read = 1'b0; ex_rt = 5'd0;
    branch_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // ctl = {pc_write, ifid_write, en_single, ifid_flush, pipe_hold}
  task automatic chk_ctl(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, pc_write, ifid_write, en_single,
              ifid_flush, pipe_hold}, {27'd0, exp});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk_ctl("rst_ctl", 5'b00001);
    chk("rst_cnt", {16'd0, stall_cycles}, 32'd0);
    chk("rst_to", {31'd0, mem_timeout}, 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk_ctl("normal", 5'b11100);

    // load-use on rs: one bubble
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1 chk_ctl("lu_rs", 5'b00000);
    tick();
    ex_mem_read = 1'b0;
    #1 chk_ctl("lu_after", 5'b11100);
    chk("lu_cnt", {16'd0, stall_cycles}, 32'd1);

    // $zero destination never stalls
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    #1 chk_ctl("lu_r0", 5'b11100);
    tick();
    chk("lu_r0_cnt", {16'd0, stall_cycles}, 32'd1);
    // rt match ignored unless rt is a source
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1 chk_ctl("lu_rt_unused", 5'b11100);
    id_uses_rt = 1'b1;
    #1 chk_ctl("lu_rt_used", 5'b00000);
    tick();
    chk("lu_rt_cnt", {16'd0, stall_cycles}, 32'd2);

    // branch beats a simultaneous load-use
    ex_rt = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
    #1 chk_ctl("br_lu", 5'b11010);
    tick();
    chk("br_cnt", {16'd0, stall_cycles}, 32'd2);
    idle();

    // 3-cycle memory wait, branch ignored while holding
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) branch_taken = 1'b1;
      #1 chk_ctl($sformatf("mw_hold%0d", i), 5'b00101);
      tick();
    end
    mem_ready = 1'b1;
    #1 chk_ctl("mw_release_br", 5'b11010);
    tick();
    idle();
    #1 chk_ctl("mw_run", 5'b11100);
    chk("mw_cnt", {16'd0, stall_cycles}, 32'd5);

    // mem_req dropping during the wait releases it
    mem_req = 1'b1;
    #1 chk_ctl("mr_hold", 5'b00101);
    tick();
    mem_req = 1'b0;
    #1 chk_ctl("mr_drop", 5'b11100);
    tick();
    chk("mr_cnt", {16'd0, stall_cycles}, 32'd6);

    // timeout: 16 hold cycles, then sticky ERR
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 chk_ctl($sformatf("to_hold%0d", i), 5'b00101);
      chk($sformatf("to_flag%0d", i), {31'd0, mem_timeout}, 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    #1 chk_ctl("err_ctl", 5'b00001);
    chk("err_flag", {31'd0, mem_timeout}, 32'd1);
    chk("err_cnt", {16'd0, stall_cycles}, 32'd22);
    tick();
    mem_req = 1'b0;
    #1 chk_ctl("err_sticky", 5'b00001);
    chk("err_flag2", {31'd0, mem_timeout}, 32'd1);
    chk("err_cnt2", {16'd0, stall_cycles}, 32'd23);

    // asynchronous reset mid-ERR, checked before the next edge
    #1 rst_n = 1'b0;
    #1 chk_ctl("arst_ctl", 5'b00001);
    chk("arst_flag", {31'd0, mem_timeout}, 32'd0);
    chk("arst_cnt", {16'd0, stall_cycles}, 32'd0);
    tick();
    rst_n = 1'b1;
    idle();
    #1 chk_ctl("arst_run", 5'b11100);

    // 20 consecutive load-use stalls saturate the 4-bit counter
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < 20; i++) tick();
    chk("sat4", {28'd0, stall_cycles4}, 32'd15);
    chk("sat16", {16'd0, stall_cycles}, 32'd20);
    tick();
    chk("sat4_hold", {28'd0, stall_cycles4}, 32'd15);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Pipeline sequencing controller for the single-issue MIPS core.
- Drives the control-zeroing mux enable (en_single), PC/IF-ID write enables, IF/ID flush and a global pipeline hold.
- Resolves three hazards: load-use, taken branch/jump squash, and multi-cycle data-memory wait with timeout.
- Sits between the ID/EX stage registers and the main control-signal path; keeps a saturating stall-cycle counter for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register specifier width
- MEM_TIMEOUT, 16, consecutive not-ready memory cycles before fatal error (must be ≥2)
- CNT_W, 16, width of stall_cycles counter

Ports:
- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs  in  REG_ADDR_W  rs of instruction in ID
- id_rt  in  REG_ADDR_W  rt of instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- ex_mem_read  in  1  instruction in EX is a load
- ex_rt  in  REG_ADDR_W  destination of load in EX
- branch_taken  in  1  EX resolved a taken branch/jump this cycle
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_write  out  1  PC update enable
- ifid_write  out  1  IF/ID register write enable
- en_single  out  1  1 = pass control signals, 0 = insert bubble (all controls zero)
- ifid_flush  out  1  clear IF/ID to NOP
- pipe_hold  out  1  freeze every pipeline register (ID/EX, EX/MEM, MEM/WB)
- mem_timeout  out  1  sticky fatal memory-timeout flag
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately even mid-wait):
  - State := RUN, wait_cnt := 0, stall_cycles := 0, mem_timeout := 0.
  - While rst_n=0, outputs forced to pc_write=0, ifid_write=0, en_single=0, ifid_flush=0, pipe_hold=1.
- States: RUN, MEM_WAIT, ERR. Outputs are combinational from state and current inputs (zero-latency stall); state, wait_cnt, mem_timeout and stall_cycles are registered.
- load_use = ex_mem_read & (ex_rt≠0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
- mem_stall = mem_req & ~mem_ready.
- RUN, priority mem_stall > branch_taken > load_use > normal:
  - mem_stall: pipe_hold=1, pc_write=0, ifid_write=0, en_single=1, ifid_flush=0; wait_cnt := 1; next state MEM_WAIT.
  - branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, en_single=0 (squashes both wrong-path instructions), pipe_hold=0. A simultaneous load_use is ignored.
  - load_use: pc_write=0, ifid_write=0, en_single=0 (one bubble), ifid_flush=0, pipe_hold=0. Exactly one stall cycle per hazard, since the load leaves EX on the next edge.
  - normal: pc_write=1, ifid_write=1, en_single=1, ifid_flush=0, pipe_hold=0.
- MEM_WAIT:
  - mem_ready=1: release in the same cycle. Outputs are evaluated as in RUN with mem_stall=0, including branch/load-use detection. Next state RUN, wait_cnt := 0.
  - mem_ready=0: outputs as the RUN mem_stall case; wait_cnt += 1.
    - wait_cnt==MEM_TIMEOUT-1 → next state ERR, mem_timeout := 1.
  - branch_taken/load_use are ignored while holding. EX inputs stay stable because the pipeline is frozen.
- ERR: pipe_hold=1, pc_write=0, ifid_write=0, en_single=0, ifid_flush=0. Exit only via rst_n; mem_timeout stays 1.
- stall_cycles: increments on each edge where pc_write=0 and rst_n=1. Saturates at 2^CNT_W−1 with no wrap. Counts ERR cycles.
- mem_req deasserting during MEM_WAIT is treated as mem_ready=1.

Test Plan:
- ex_mem_read=1, ex_rt=8, id_rs=8 for one cycle, then ex_mem_read=0 → that cycle pc_write=0, ifid_write=0, en_single=0; next cycle all 1; stall_cycles=1.
- ex_mem_read=1, ex_rt=0, id_rs=0 → no stall; pc_write=1, en_single=1, stall_cycles=0. Repeat with ex_rt=9, id_rt=9, id_uses_rt=0 → no stall.
- branch_taken=1 with load_use true in the same cycle → ifid_flush=1, en_single=0, pc_write=1, pipe_hold=0; stall_cycles unchanged.
- mem_req=1, mem_ready=0 for 3 cycles then 1 → pipe_hold=1 and pc_write=0 for exactly 3 cycles; deasserted in the ready cycle; state back to RUN; stall_cycles=3.
- MEM_TIMEOUT=16, mem_ready held 0 → after 16 hold cycles state=ERR, mem_timeout=1 sticky, pipe_hold=1 with mem_ready later 1. Then rst_n=0 asynchronously → outputs at reset values before the next clk edge, mem_timeout=0.
- CNT_W=4, 20 consecutive load-use stalls → stall_cycles saturates at 15 and holds.
